// File: rtl/sevenseg_display_ctrl.sv
// sevenseg_display_ctrl
// Converts a binary value to six BCD digits with an iterative shift-add-3
// (double-dabble) engine and presents digits, leading-zero blank mask and
// decimal-point mask to the seven-segment decoder bank as one atomic update.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   value_in     binary value to display (saturated to MAX_VAL)
//   value_valid  value_in / dp_pos / lz_blank_en are valid
//   value_ready  controller can accept a value (IDLE)
//   dp_pos       digit index 0..5 carrying the decimal point, 6/7 = none
//   lz_blank_en  enable leading-zero blanking
//   num_hex      packed BCD digits, [3:0] = digit 0 (rightmost)
//   blank        per-digit blank, bit i = digit i
//   dp           per-digit decimal point
//   busy         conversion in progress
//   overflow     displayed value was saturated
//
// Optional feature macro: SEVENSEG_OVF_BLINK_EN
//   When defined, adds parameter BLINK_HALF and blinks the whole display
//   (blank forced to all ones on alternate half-periods) while overflow = 1.

module sevenseg_display_ctrl #(
    parameter int WIDTH   = 20,
    parameter int MAX_VAL = 999999
`ifdef SEVENSEG_OVF_BLINK_EN
    ,
    parameter int BLINK_HALF = 25000000
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] value_in,
    input  logic             value_valid,
    output logic             value_ready,
    input  logic [2:0]       dp_pos,
    input  logic             lz_blank_en,
    output logic [23:0]      num_hex,
    output logic [5:0]       blank,
    output logic [5:0]       dp,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [19:0] bin;
    logic [23:0] bcd;
    logic [4:0]  cnt;
    logic        ovf_h;
    logic [2:0]  dp_h;
    logic        lz_h;
    logic [5:0]  blank_q;

    logic             in_ovf;
    logic [WIDTH-1:0] sat;
    logic [23:0]      bcd_adj;
    logic [5:0]       lz_mask;
    logic [5:0]       dp_mask;
    logic             zero_above;

    assign in_ovf = (value_in > WIDTH'(MAX_VAL));
    assign sat    = in_ovf ? WIDTH'(MAX_VAL) : value_in;

    // Add-3 correction on every nibble >= 5 before the shift; carries never
    // leave the nibble because 9+3 still fits in 4 bits.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 6; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            else
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4];
        end
    end

    // Leading-zero mask: walk from the top digit down while all digits seen
    // so far are zero. Digit 0 and digits at/right of the DP stay lit.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            zero_above = zero_above & (bcd[i*4 +: 4] == 4'd0);
            lz_mask[i] = lz_h && zero_above && (i != 0) &&
                         ((dp_h >= 3'd6) || (3'(i) > dp_h));
        end
    end

    assign dp_mask = (dp_h < 3'd6) ? (6'b000001 << dp_h) : 6'b000000;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            bin         <= '0;
            bcd         <= '0;
            cnt         <= '0;
            ovf_h       <= 1'b0;
            dp_h        <= 3'd7;
            lz_h        <= 1'b0;
            num_hex     <= '0;
            blank_q     <= 6'b111110;
            dp          <= '0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            value_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (value_valid) begin
                        // Saturated value always fits in the low 20 bits.
                        bin         <= sat[19:0];
                        bcd         <= '0;
                        cnt         <= '0;
                        ovf_h       <= in_ovf;
                        dp_h        <= dp_pos;
                        lz_h        <= lz_blank_en;
                        busy        <= 1'b1;
                        value_ready <= 1'b0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= {bcd_adj[22:0], bin[19]};
                    bin <= {bin[18:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd19)
                        state <= DONE;
                end
                DONE: begin
                    num_hex     <= bcd;
                    blank_q     <= lz_mask;
                    dp          <= dp_mask;
                    overflow    <= ovf_h;
                    busy        <= 1'b0;
                    value_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEVENSEG_OVF_BLINK_EN
    // Half-period counter plus phase bit; restarts on every new result so a
    // fresh overflow always begins with the normal mask visible.
    logic [$clog2(BLINK_HALF+1)-1:0] blink_cnt;
    logic                            blink_phase;

    always_ff @(posedge clk) begin
        if (!reset_n || state == DONE) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == $bits(blink_cnt)'(BLINK_HALF - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blank = (overflow && blink_phase) ? 6'b111111 : blank_q;
`else
    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_sevenseg_display_ctrl.sv
module tb_sevenseg_display_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [19:0] value_in;
    logic        value_valid;
    logic        value_ready;
    logic [2:0]  dp_pos;
    logic        lz_blank_en;
    logic [23:0] num_hex;
    logic [5:0]  blank;
    logic [5:0]  dp;
    logic        busy;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;

    sevenseg_display_ctrl #(.WIDTH(20), .MAX_VAL(999999)) dut (
        .clk(clk), .reset_n(reset_n), .value_in(value_in),
        .value_valid(value_valid), .value_ready(value_ready),
        .dp_pos(dp_pos), .lz_blank_en(lz_blank_en), .num_hex(num_hex),
        .blank(blank), .dp(dp), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Drives one transaction E0..E21 and reports whether the handshake and
    // output-stability sequence looked right; checks are done by callers.
    task automatic convert(input logic [19:0] v, input logic [2:0] d,
                           input logic l, output bit seq_ok);
        int n;
        logic [23:0] prev;
        seq_ok = 1'b1;
        n = 0;
        while (value_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (value_ready !== 1'b1) seq_ok = 1'b0;
        value_in = v; dp_pos = d; lz_blank_en = l; value_valid = 1'b1;
        @(posedge clk); #1;                       // E0
        value_valid = 1'b0;
        value_in = ~v; dp_pos = 3'd0; lz_blank_en = ~l;  // must be ignored
        prev = num_hex;
        if (value_ready !== 1'b0 || busy !== 1'b1) seq_ok = 1'b0;
        repeat (20) begin                         // E1..E20
            @(posedge clk); #1;
            if (value_ready !== 1'b0 || busy !== 1'b1 || num_hex !== prev)
                seq_ok = 1'b0;
        end
        @(posedge clk); #1;                       // E21
        if (value_ready !== 1'b1 || busy !== 1'b0) seq_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        compared++;
        if (num_hex !== 24'h0 || blank !== 6'b111110 || dp !== 6'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: num_hex=%h blank=%b dp=%b, want 000000 111110 000000",
                     num_hex, blank, dp);
        end
        compared++;
        if (overflow !== 1'b0 || busy !== 1'b0 || value_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_flags: ovf=%b busy=%b ready=%b, want 0 0 1",
                     overflow, busy, value_ready);
        end
    endtask

    task automatic test_basic();
        bit ok;
        convert(20'd123456, 3'd7, 1'b0, ok);
        compared++;
        if (ok !== 1'b1) begin
            mismatched++; $display("FAIL basic_seq: got %b want 1", ok);
        end
        compared++;
        if (num_hex !== 24'h123456 || blank !== 6'b0 || dp !== 6'b0 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_out: num_hex=%h blank=%b dp=%b ovf=%b, want 123456 000000 000000 0",
                     num_hex, blank, dp, overflow);
        end
    endtask

    task automatic test_lz();
        bit ok;
        convert(20'd42, 3'd7, 1'b1, ok);
        compared++;
        if (ok !== 1'b1) begin
            mismatched++; $display("FAIL lz_seq: got %b want 1", ok);
        end
        compared++;
        if (num_hex !== 24'h000042 || blank !== 6'b111100 || dp !== 6'b0) begin
            mismatched++;
            $display("FAIL lz_out: num_hex=%h blank=%b dp=%b, want 000042 111100 000000",
                     num_hex, blank, dp);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        convert(20'd1000000, 3'd7, 1'b0, ok);
        compared++;
        if (ok !== 1'b1 || num_hex !== 24'h999999 || overflow !== 1'b1) begin
            mismatched++;
            $display("FAIL sat_out: ok=%b num_hex=%h ovf=%b, want 1 999999 1", ok, num_hex, overflow);
        end
        convert(20'd999999, 3'd7, 1'b0, ok);
        compared++;
        if (num_hex !== 24'h999999 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL sat_limit: num_hex=%h ovf=%b, want 999999 0", num_hex, overflow);
        end
        convert(20'd7, 3'd7, 1'b0, ok);
        compared++;
        if (num_hex !== 24'h000007 || overflow !== 1'b0 || blank !== 6'b0) begin
            mismatched++;
            $display("FAIL sat_clear: num_hex=%h ovf=%b blank=%b, want 000007 0 000000",
                     num_hex, overflow, blank);
        end
    endtask

    task automatic test_dp();
        bit ok;
        convert(20'd5, 3'd2, 1'b1, ok);
        compared++;
        if (num_hex !== 24'h000005 || blank !== 6'b111000 || dp !== 6'b000100) begin
            mismatched++;
            $display("FAIL dp_out: num_hex=%h blank=%b dp=%b, want 000005 111000 000100",
                     num_hex, blank, dp);
        end
        convert(20'd0, 3'd0, 1'b1, ok);
        compared++;
        if (num_hex !== 24'h0 || blank !== 6'b111110 || dp !== 6'b000001) begin
            mismatched++;
            $display("FAIL dp_zero: num_hex=%h blank=%b dp=%b, want 000000 111110 000001",
                     num_hex, blank, dp);
        end
        convert(20'd800, 3'd5, 1'b1, ok);
        compared++;
        if (num_hex !== 24'h000800 || blank !== 6'b000000 || dp !== 6'b100000) begin
            mismatched++;
            $display("FAIL dp_top: num_hex=%h blank=%b dp=%b, want 000800 000000 100000",
                     num_hex, blank, dp);
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        bit ok;
        value_in = 20'd111111; dp_pos = 3'd7; lz_blank_en = 1'b0; value_valid = 1'b1;
        @(posedge clk); #1;                       // E0
        ok = 1'b1;
        for (edges = 1; edges <= 21; edges++) begin
            @(posedge clk); #1;
            if (edges == 4) value_in = 20'd222222;   // changed before E5
            if (edges <= 20 && value_ready !== 1'b0) ok = 1'b0;
        end
        compared++;
        if (ok !== 1'b1 || num_hex !== 24'h111111) begin
            mismatched++;
            $display("FAIL b2b_first: ok=%b num_hex=%h, want 1 111111", ok, num_hex);
        end
        @(posedge clk); #1;                       // E22 accepts second value
        value_valid = 1'b0;
        compared++;
        if (value_ready !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_accept: ready=%b busy=%b, want 0 1", value_ready, busy);
        end
        repeat (21) begin @(posedge clk); #1; end
        compared++;
        if (num_hex !== 24'h222222 || value_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_second: num_hex=%h ready=%b, want 222222 1", num_hex, value_ready);
        end
    endtask

    task automatic test_reset_mid();
        value_in = 20'd654321; dp_pos = 3'd1; lz_blank_en = 1'b1; value_valid = 1'b1;
        @(posedge clk); #1;                       // E0
        value_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end  // E1..E9
        reset_n = 1'b0;
        @(posedge clk); #1;                       // E10
        reset_n = 1'b1;
        compared++;
        if (num_hex !== 24'h0 || blank !== 6'b111110 || dp !== 6'b0 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_out: num_hex=%h blank=%b dp=%b ovf=%b, want 000000 111110 000000 0",
                     num_hex, blank, dp, overflow);
        end
        compared++;
        if (value_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_flags: ready=%b busy=%b, want 1 0", value_ready, busy);
        end
        repeat (25) begin @(posedge clk); #1; end
        compared++;
        if (num_hex !== 24'h0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_abandon: num_hex=%h busy=%b, want 000000 0", num_hex, busy);
        end
    endtask

    initial begin
        reset_n = 1'b0; value_in = '0; value_valid = 1'b0;
        dp_pos = 3'd7; lz_blank_en = 1'b0;
        test_reset();
        test_basic();
        test_lz();
        test_saturate();
        test_dp();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sevenseg_display_ctrl.md
Name: sevenseg_display_ctrl

Overview:
- Sequencing controller that drives the six-digit seven-segment decoder bank from a single binary value.
- Accepts a binary value over a valid/ready handshake and converts it to six BCD digits with an iterative shift-add-3 (double-dabble) engine.
- Derives leading-zero blanking and the decimal-point position, then presents digits, blank mask and DP mask to the decoder bank as one atomic update.
- Sits between the NCO measurement/readout logic and the display decoders.

Parameters:
- WIDTH, 20, binary input width; must be ≥20 so 999999 is representable.
- MAX_VAL, 999999, saturation limit for the displayed value.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- value_in  input  WIDTH  binary value to display
- value_valid  input  1  value_in/dp_pos/lz_blank_en are valid
- value_ready  output  1  controller can accept a value
- dp_pos  input  3  digit index 0..5 carrying the decimal point; 6 or 7 = no DP
- lz_blank_en  input  1  enable leading-zero blanking
- num_hex  output  24  packed BCD digits; [3:0] = digit 0 (rightmost), [23:20] = digit 5
- blank  output  6  per-digit blank to decoders; bit i = digit i
- dp  output  6  per-digit decimal point to decoders
- busy  output  1  conversion in progress
- overflow  output  1  displayed value was saturated

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is synchronous and active-low (reset_n), sampled on the rising edge of clk.
- Reset values:
  - num_hex = 0, blank = 6'b111110 (display shows "0"), dp = 0.
  - overflow = 0, busy = 0, value_ready = 1, state = IDLE.
- States:
  - IDLE: value_ready = 1, busy = 0.
    - On the edge with value_valid & value_ready, capture sat = (value_in > MAX_VAL) ? MAX_VAL : value_in.
    - Capture ovf = (value_in > MAX_VAL), dp_pos and lz_blank_en into holding registers.
    - Clear the 24-bit BCD accumulator, set bit counter = 0, go to SHIFT.
  - SHIFT: value_ready = 0, busy = 1.
    - Each cycle, for every BCD nibble ≥ 5, add 3 (4-bit add, no carry out of the nibble).
    - Then shift {bcd, bin} left by 1 and increment the counter.
    - After exactly 20 shift cycles (counter reaches 19 on the last one), go to DONE.
  - DONE: busy = 1, value_ready = 0.
    - Register num_hex, blank, dp and overflow simultaneously, then return to IDLE.
- Latency:
  - Acceptance edge = E0. Shifts occur on E1..E20. Outputs update on E21.
  - value_ready returns to 1 after E21, so a new value can be accepted on E22.
- Output stability: num_hex, blank, dp and overflow change only in DONE. The decoders never see partially converted digits.
- Only the low 20 bits of the saturated value feed the shifter; bits above are always zero after saturation.
- Blank mask:
  - Digit i is blanked iff lz_blank_en = 1, digit i and all higher digits are 0, i ≠ 0, and i > dp_pos.
  - Digit 0 and all digits at or right of the DP are never blanked.
  - With lz_blank_en = 0, blank = 0.
- DP mask: dp = one-hot(dp_pos) for dp_pos 0..5; 0 for dp_pos 6/7.
- value_valid during SHIFT/DONE is ignored; nothing is queued. The requester holds valid until it sees ready.
- A reset_n low during SHIFT/DONE abandons the conversion; all outputs take their reset values on that edge.
- Input changes after the acceptance edge have no effect on the running conversion.

Optional Feature:
- Macro SEVENSEG_OVF_BLINK_EN.
- Defined:
  - Adds parameter BLINK_HALF, default 25000000, and a free-running counter.
  - While overflow = 1, blank is forced to 6'b111111 during alternate BLINK_HALF-cycle half-periods; the other half-period shows the normal mask.
  - The counter resets to 0 on reset_n and on each DONE.
  - While overflow = 0, behaviour is identical to the macro being undefined.
- Undefined: no counter is built; blank is purely the leading-zero mask.

Test Plan:
- Reset, then value_in = 123456, dp_pos = 7, lz = 0 -> on E21: num_hex = 24'h123456, blank = 0, dp = 0, overflow = 0. value_ready is 0 from E1 to E21.
- value_in = 42, dp_pos = 7, lz = 1 -> num_hex = 24'h000042, blank = 6'b111100, dp = 0.
- value_in = 1000000, lz = 0 -> num_hex = 24'h999999, overflow = 1. Then value_in = 7 -> overflow = 0, num_hex = 24'h000007.
- value_in = 5, dp_pos = 2, lz = 1 -> num_hex = 24'h000005, blank = 6'b111000, dp = 6'b000100 (displays "0.05").
- value_valid held high with 111111 then 222222 changed on E5 -> the second value is not accepted until E22; the first result is 24'h111111.
- reset_n low at E10 of a conversion -> outputs return to reset values (blank = 6'b111110), value_ready = 1 on the next cycle.
